// File: rtl/nes_pad_responder.sv
// Controller-side NES pad emulator: answers a host latch/pulse poll with the 8 button
// states shifted out active-low on nes_data, in the manner of a 4021 shift register.

module nes_pad_in_cond #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic prev
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   filtered;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], pin};
  end

  assign synced = sync[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign filtered = synced;
    end else begin : g_filter
      logic [CNT_W-1:0] cnt;
      logic             flt_q;

      // The level only moves after FILTER_CYCLES consecutive clocks of disagreement.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt   <= '0;
          flt_q <= 1'b0;
        end else if (synced == flt_q) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
          cnt   <= '0;
          flt_q <= synced;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign filtered = flt_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= filtered;
      prev  <= level;
    end
  end

endmodule

module nes_pad_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_latch,
  input  logic       nes_pulse,
  input  logic [7:0] buttons,
  output logic       nes_data,
  output logic       poll_strobe,
  output logic [3:0] shift_count,
  output logic       overread
);

  logic [1:0] rst_pipe;
  logic       rst;
  logic       latch_lvl, latch_prev;
  logic       pulse_lvl, pulse_prev;
  logic       load, latch_fall, pulse_rise;
  logic [7:0] shift_reg;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst = rst_pipe[1];

  nes_pad_in_cond #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_latch_cond (
    .clk  (clk),
    .rst  (rst),
    .pin  (nes_latch),
    .level(latch_lvl),
    .prev (latch_prev)
  );

  nes_pad_in_cond #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_pulse_cond (
    .clk  (clk),
    .rst  (rst),
    .pin  (nes_pulse),
    .level(pulse_lvl),
    .prev (pulse_prev)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    load       = 1'b0;
    latch_fall = 1'b0;
    pulse_rise = 1'b0;
    load       = latch_lvl;
    latch_fall = latch_prev & ~latch_lvl;
    pulse_rise = pulse_lvl & ~pulse_prev;
  end

  // A pulse edge coinciding with the latch fall shifts the freshly committed snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg   <= 8'hFF;
      shift_count <= 4'd0;
      overread    <= 1'b0;
      poll_strobe <= 1'b0;
    end else begin
      poll_strobe <= latch_fall;
      if (load) begin
        shift_reg   <= ~buttons;
        shift_count <= 4'd0;
        overread    <= 1'b0;
      end else if (pulse_rise) begin
        shift_reg <= {1'b1, shift_reg[7:1]};
        if (shift_count == 4'd8) overread    <= 1'b1;
        else                     shift_count <= shift_count + 4'd1;
      end
    end
  end

  assign nes_data = shift_reg[0];

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: scripted and randomized polls compared
// against a frame-level model of what a pad should answer after n pulses.

module tb_nes_pad_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic       nes_data;
  logic       poll_strobe;
  logic [3:0] shift_count;
  logic       overread;

  int checks = 0;
  int passes = 0;
  int strobe_cycles = 0;

  nes_pad_responder #(
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .nes_latch  (nes_latch),
    .nes_pulse  (nes_pulse),
    .buttons    (buttons),
    .nes_data   (nes_data),
    .poll_strobe(poll_strobe),
    .shift_count(shift_count),
    .overread   (overread)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (poll_strobe) strobe_cycles++;

  // Pad model: after n pulses the reply is the (n)th button, active-low, then released.
  function automatic logic exp_data(input logic [7:0] snap, input int n);
    return (n < 8) ? ~snap[n] : 1'b1;
  endfunction

  function automatic logic [3:0] exp_count(input int n);
    return (n < 8) ? 4'(n) : 4'd8;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_latch(input int clks);
    nes_latch = 1'b1;
    tick(clks);
    nes_latch = 1'b0;
    tick(8);
  endtask

  task automatic do_pulse(input int hi, input int lo);
    nes_pulse = 1'b1;
    tick(hi);
    nes_pulse = 1'b0;
    tick(lo);
  endtask

  task automatic test_reset;
    reset = 1'b1; nes_latch = 1'b0; nes_pulse = 1'b0; buttons = 8'h00;
    tick(3);
    checks++; if (nes_data !== 1'b1) $display("FAIL reset_data: got %b expected 1", nes_data); else passes++;
    checks++; if (shift_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", shift_count); else passes++;
    checks++; if (poll_strobe !== 1'b0 || overread !== 1'b0)
      $display("FAIL reset_flags: got strobe=%b over=%b expected 0 0", poll_strobe, overread); else passes++;
    reset = 1'b0;
    tick(4);
    checks++; if (nes_data !== 1'b1 || shift_count !== 4'd0)
      $display("FAIL post_reset: got data=%b count=%0d expected 1 0", nes_data, shift_count); else passes++;
  endtask

  task automatic test_latency;
    buttons = 8'h01;
    nes_latch = 1'b1;
    tick(6);
    checks++; if (nes_data !== 1'b1) $display("FAIL latency_early: got %b expected 1", nes_data); else passes++;
    tick(1);
    checks++; if (nes_data !== 1'b0) $display("FAIL latency_edge: got %b expected 0", nes_data); else passes++;
    tick(5);
    nes_latch = 1'b0;
    tick(8);
  endtask

  task automatic test_poll;
    logic [7:0] snap;
    int s0;
    snap = 8'b0000_1001;
    buttons = snap;
    s0 = strobe_cycles;
    do_latch(12);
    checks++; if (strobe_cycles - s0 !== 1) $display("FAIL poll_strobe: got %0d cycles expected 1", strobe_cycles - s0); else passes++;
    checks++; if (nes_data !== exp_data(snap, 0)) $display("FAIL poll_bit0: got %b expected %b", nes_data, exp_data(snap, 0)); else passes++;
    for (int i = 1; i <= 8; i++) begin
      do_pulse(10, 10);
      checks++; if (nes_data !== exp_data(snap, i) || shift_count !== exp_count(i))
        $display("FAIL poll_pulse%0d: got data=%b count=%0d expected %b %0d", i, nes_data, shift_count, exp_data(snap, i), exp_count(i));
      else passes++;
    end
  endtask

  task automatic test_overread;
    for (int i = 9; i <= 10; i++) begin
      do_pulse(10, 10);
      checks++; if (nes_data !== 1'b1 || overread !== 1'b1 || shift_count !== 4'd8)
        $display("FAIL overread_pulse%0d: got data=%b over=%b count=%0d expected 1 1 8", i, nes_data, overread, shift_count);
      else passes++;
    end
    do_latch(12);
    checks++; if (overread !== 1'b0 || shift_count !== 4'd0)
      $display("FAIL overread_clear: got over=%b count=%0d expected 0 0", overread, shift_count); else passes++;
  endtask

  task automatic test_glitch;
    logic [7:0] snap;
    snap = 8'b0101_0110;
    buttons = snap;
    do_latch(10);
    do_pulse(10, 10);
    do_pulse(10, 10);
    do_pulse(2, 12);
    checks++; if (shift_count !== 4'd2 || nes_data !== exp_data(snap, 2))
      $display("FAIL glitch_2clk: got count=%0d data=%b expected 2 %b", shift_count, nes_data, exp_data(snap, 2)); else passes++;
    do_pulse(4, 12);
    checks++; if (shift_count !== 4'd3 || nes_data !== exp_data(snap, 3))
      $display("FAIL glitch_4clk: got count=%0d data=%b expected 3 %b", shift_count, nes_data, exp_data(snap, 3)); else passes++;
  endtask

  task automatic test_mid_latch_change;
    logic [7:0] got;
    buttons = 8'h01;
    nes_latch = 1'b1;
    tick(10);
    buttons = 8'h02;
    tick(10);
    nes_latch = 1'b0;
    tick(8);
    buttons = 8'h00;
    got[0] = nes_data;
    for (int i = 1; i < 8; i++) begin
      do_pulse(10, 10);
      got[i] = nes_data;
    end
    checks++; if (got !== 8'hFD) $display("FAIL mid_latch_read: got %b expected 11111101", got); else passes++;
  endtask

  task automatic test_pulse_in_latch;
    logic [7:0] snap;
    snap = 8'($urandom);
    buttons = snap;
    nes_latch = 1'b1;
    tick(8);
    do_pulse(10, 10);
    checks++; if (shift_count !== 4'd0 || nes_data !== ~snap[0])
      $display("FAIL pulse_in_latch: got count=%0d data=%b expected 0 %b", shift_count, nes_data, ~snap[0]); else passes++;
    nes_pulse = 1'b1;
    tick(10);
    nes_latch = 1'b0;
    tick(10);
    nes_pulse = 1'b0;
    tick(10);
    checks++; if (shift_count !== 4'd0 || nes_data !== ~snap[0])
      $display("FAIL pulse_across_fall: got count=%0d data=%b expected 0 %b", shift_count, nes_data, ~snap[0]); else passes++;
  endtask

  task automatic test_simultaneous;
    logic [7:0] snap;
    snap = 8'b1010_0101;
    buttons = snap;
    nes_latch = 1'b1;
    tick(12);
    nes_latch = 1'b0;
    nes_pulse = 1'b1;
    tick(10);
    nes_pulse = 1'b0;
    tick(10);
    checks++; if (shift_count !== 4'd1 || nes_data !== exp_data(snap, 1))
      $display("FAIL simultaneous: got count=%0d data=%b expected 1 %b", shift_count, nes_data, exp_data(snap, 1)); else passes++;
  endtask

  task automatic test_random_frames;
    logic [7:0] snap;
    int n;
    for (int f = 0; f < 6; f++) begin
      snap = 8'($urandom);
      n = int'($urandom_range(0, 10));
      buttons = snap;
      do_latch(int'($urandom_range(6, 15)));
      buttons = 8'($urandom);
      checks++; if (nes_data !== exp_data(snap, 0) || shift_count !== 4'd0)
        $display("FAIL rand%0d_load: got data=%b count=%0d expected %b 0", f, nes_data, shift_count, exp_data(snap, 0)); else passes++;
      for (int i = 1; i <= n; i++) begin
        do_pulse(int'($urandom_range(5, 10)), int'($urandom_range(5, 10)));
        checks++; if (nes_data !== exp_data(snap, i) || shift_count !== exp_count(i) || overread !== (i > 8))
          $display("FAIL rand%0d_pulse%0d: got data=%b count=%0d over=%b expected %b %0d %b", f, i,
                   nes_data, shift_count, overread, exp_data(snap, i), exp_count(i), (i > 8));
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid;
    buttons = 8'hFF;
    do_latch(12);
    for (int i = 0; i < 3; i++) do_pulse(10, 10);
    #3 reset = 1'b1;
    #1;
    checks++; if (nes_data !== 1'b1 || shift_count !== 4'd0)
      $display("FAIL reset_async: got data=%b count=%0d expected 1 0", nes_data, shift_count); else passes++;
    tick(2);
    reset = 1'b0;
    tick(4);
    for (int i = 1; i <= 2; i++) begin
      do_pulse(10, 10);
      checks++; if (nes_data !== 1'b1 || shift_count !== 4'(i))
        $display("FAIL reset_then_pulse%0d: got data=%b count=%0d expected 1 %0d", i, nes_data, shift_count, i); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_poll();
    test_overread();
    test_glitch();
    test_mid_latch_change();
    test_pulse_in_latch();
    test_simultaneous();
    test_random_frames();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
